// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch decode, one-cycle condition evaluation and resolved-PC handshake
module branch_resolve_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    input  logic             flush,
    output logic [31:0]      bceu_a,
    output logic [31:0]      bceu_b,
    output logic [3:0]       bceu_bf,
    input  logic             bceu_bcres,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_is_branch,
    output logic             res_taken,
    output logic [31:0]      res_pc,
    output logic [31:0]      res_target,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [31:0]      target_q, target_d;
    logic             taken_q, taken_d;
    logic             is_br_q, is_br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       dec_bf;
    logic             dec_is_br;
    logic [31:0]      seq_pc;
    logic [31:0]      br_pc;

    // The rs field is not decoded; its value arrives already read on in_rs_val.
    logic unused_rs_field;
    assign unused_rs_field = ^instr_q[25:21];

    // Map opcode (and rt for the REGIMM group) onto the branch-function code.
    always_comb begin
        dec_bf    = 4'b0000;
        dec_is_br = 1'b0;
        case (instr_q[31:26])
            6'b000001: begin
                if (instr_q[20:16] == 5'b00000) begin
                    dec_bf    = 4'b0010;
                    dec_is_br = 1'b1;
                end else if (instr_q[20:16] == 5'b00001) begin
                    dec_bf    = 4'b0011;
                    dec_is_br = 1'b1;
                end
            end
            6'b000100: begin dec_bf = 4'b0100; dec_is_br = 1'b1; end
            6'b000101: begin dec_bf = 4'b0101; dec_is_br = 1'b1; end
            6'b000110: begin dec_bf = 4'b0110; dec_is_br = 1'b1; end
            6'b000111: begin dec_bf = 4'b0111; dec_is_br = 1'b1; end
            default: begin
                dec_bf    = 4'b0000;
                dec_is_br = 1'b0;
            end
        endcase
    end

    // Sequential and branch targets; both wrap silently modulo 2^32.
    always_comb begin
        seq_pc = pc_q + 32'd4;
        br_pc  = seq_pc + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end

    // Next-state logic: accept, evaluate for exactly one cycle, then hold the result until taken.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        target_d = target_q;
        taken_d  = taken_q;
        is_br_d  = is_br_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    instr_d = in_instr;
                    pc_d    = in_pc;
                    rs_d    = in_rs_val;
                    rt_d    = in_rt_val;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    taken_d  = bceu_bcres & dec_is_br;
                    is_br_d  = dec_is_br;
                    target_d = (bceu_bcres & dec_is_br) ? br_pc : seq_pc;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (res_ready) begin
                    if (taken_q && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            pc_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
            is_br_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            target_q <= target_d;
            taken_q  <= taken_d;
            is_br_q  <= is_br_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign res_valid     = (state_q == ST_RESP);
    assign bceu_a        = rs_q;
    assign bceu_b        = rt_q;
    assign bceu_bf       = (state_q == ST_EVAL) ? dec_bf : 4'b0000;
    assign res_is_branch = is_br_q;
    assign res_taken     = taken_q;
    assign res_pc        = pc_q;
    assign res_target    = target_q;
    assign taken_count   = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed table-driven bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, res_ready, bcres;
    logic [31:0] in_instr, in_pc, in_rs_val, in_rt_val;
    logic        in_ready, res_valid, res_is_branch, res_taken;
    logic [31:0] bceu_a, bceu_b, res_pc, res_target;
    logic [3:0]  bceu_bf;
    logic [15:0] taken_count;
    logic        in_ready2, res_valid2, res_is_branch2, res_taken2;
    logic [31:0] bceu_a2, bceu_b2, res_pc2, res_target2;
    logic [3:0]  bceu_bf2;
    logic [1:0]  taken_count2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .flush(flush), .bceu_a(bceu_a), .bceu_b(bceu_b), .bceu_bf(bceu_bf),
        .bceu_bcres(bcres), .res_valid(res_valid), .res_ready(res_ready),
        .res_is_branch(res_is_branch), .res_taken(res_taken), .res_pc(res_pc),
        .res_target(res_target), .taken_count(taken_count)
    );

    branch_resolve_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .flush(flush), .bceu_a(bceu_a2), .bceu_b(bceu_b2), .bceu_bf(bceu_bf2),
        .bceu_bcres(bcres), .res_valid(res_valid2), .res_ready(res_ready),
        .res_is_branch(res_is_branch2), .res_taken(res_taken2), .res_pc(res_pc2),
        .res_target(res_target2), .taken_count(taken_count2)
    );

    // Behavioural evaluation unit feeding both instances
    always_comb begin
        bcres = 1'b0;
        case (bceu_bf)
            4'b0010: bcres = $signed(bceu_a) < 0;
            4'b0011: bcres = $signed(bceu_a) >= 0;
            4'b0100: bcres = bceu_a == bceu_b;
            4'b0101: bcres = bceu_a != bceu_b;
            4'b0110: bcres = $signed(bceu_a) <= 0;
            4'b0111: bcres = $signed(bceu_a) > 0;
            default: bcres = 1'b0;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  bf;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_cnt"}, {16'd0, taken_count}, exp_cnt);
        chk({name, "_cnt_sat"}, {30'd0, taken_count2}, (exp_cnt > 3) ? 32'd3 : exp_cnt);
    endtask

    // Present one instruction in IDLE, accept it, and check the EVAL cycle.
    task automatic accept_eval(input vec_t v, input string name);
        in_instr  = v.instr;
        in_pc     = v.pc;
        in_rs_val = v.rs;
        in_rt_val = v.rt;
        in_valid  = 1'b1;
        chk({name, "_in_ready_idle"}, {31'd0, in_ready}, 1);
        step();
        in_valid = 1'b0;
        chk({name, "_eval_bf"}, {28'd0, bceu_bf}, {28'd0, v.bf});
        chk({name, "_eval_a"}, bceu_a, v.rs);
        chk({name, "_eval_b"}, bceu_b, v.rt);
        chk({name, "_eval_busy"}, {30'd0, in_ready, res_valid}, 0);
    endtask

    task automatic chk_resp(input vec_t v, input string name);
        chk({name, "_res_valid"}, {31'd0, res_valid}, 1);
        chk({name, "_is_branch"}, {31'd0, res_is_branch}, {31'd0, v.br});
        chk({name, "_taken"}, {31'd0, res_taken}, {31'd0, v.tk});
        chk({name, "_pc"}, res_pc, v.pc);
        chk({name, "_target"}, res_target, v.tgt);
        chk({name, "_in_ready_resp"}, {31'd0, in_ready}, 0);
    endtask

    initial begin
        vecs[0]  = '{32'h10220004, 32'h00001000, 32'h12345678, 32'h12345678, 4'b0100, 1'b1, 1'b1, 32'h00001014};
        vecs[1]  = '{32'h14220004, 32'h00001000, 32'h12345678, 32'h12345678, 4'b0101, 1'b1, 1'b0, 32'h00001004};
        vecs[2]  = '{32'h0420FFFF, 32'h00001000, 32'hFFFFFFFF, 32'h00000000, 4'b0010, 1'b1, 1'b1, 32'h00001000};
        vecs[3]  = '{32'h18200008, 32'h00001000, 32'h00000000, 32'h00000000, 4'b0110, 1'b1, 1'b1, 32'h00001024};
        vecs[4]  = '{32'h1C200008, 32'h00001000, 32'h00000002, 32'h00000000, 4'b0111, 1'b1, 1'b1, 32'h00001024};
        vecs[5]  = '{32'h1C200008, 32'h00001000, 32'h00000000, 32'h00000000, 4'b0111, 1'b1, 1'b0, 32'h00001004};
        vecs[6]  = '{32'h00221820, 32'h00001000, 32'h00000005, 32'h00000005, 4'b0000, 1'b0, 1'b0, 32'h00001004};
        vecs[7]  = '{32'h0421FFF0, 32'h00001000, 32'h00000000, 32'h00000000, 4'b0011, 1'b1, 1'b1, 32'h00000FC4};
        vecs[8]  = '{32'h14220004, 32'hFFFFFFFC, 32'h00000001, 32'h00000001, 4'b0101, 1'b1, 1'b0, 32'h00000000};
        vecs[9]  = '{32'h10220004, 32'hFFFFFFF8, 32'h00000007, 32'h00000007, 4'b0100, 1'b1, 1'b1, 32'h0000000C};
        vecs[10] = '{32'h04220010, 32'h00001000, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 32'h00001004};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs_val = '0; in_rt_val = '0;
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_res_flags", {29'd0, res_valid, res_is_branch, res_taken}, 0);
        chk("rst_res_pc", res_pc, 0);
        chk("rst_res_target", res_target, 0);
        chk("rst_bceu_a", bceu_a, 0);
        chk("rst_bceu_b", bceu_b, 0);
        chk("rst_bceu_bf", {28'd0, bceu_bf}, 0);
        chk_cnt("rst");
        rst_n = 1'b1;
        step();

        // Table: full-rate transactions with res_ready held high
        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            accept_eval(vecs[i], nm);
            step();
            chk_resp(vecs[i], nm);
            step();
            if (vecs[i].tk) exp_cnt++;
            chk({nm, "_back_idle"}, {30'd0, in_ready, res_valid}, 2);
            chk_cnt(nm);
        end

        // Backpressure: result held stable for 5 cycles
        res_ready = 1'b0;
        accept_eval(vecs[0], "bp");
        step();
        for (int c = 0; c < 5; c++) begin
            chk_resp(vecs[0], $sformatf("bp_hold%0d", c));
            step();
        end
        chk_cnt("bp_held");
        res_ready = 1'b1;
        step();
        exp_cnt++;
        chk("bp_release_idle", {30'd0, in_ready, res_valid}, 2);
        chk_cnt("bp_release");

        // Flush during EVAL
        accept_eval(vecs[0], "fl_eval");
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_eval_idle", {30'd0, in_ready, res_valid}, 2);
        step();
        chk("fl_eval_no_res", {31'd0, res_valid}, 0);
        chk_cnt("fl_eval");

        // Flush in RESP together with res_ready
        accept_eval(vecs[0], "fl_resp");
        step();
        chk_resp(vecs[0], "fl_resp");
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_resp_idle", {30'd0, in_ready, res_valid}, 2);
        chk_cnt("fl_resp");

        // Flush in IDLE blocks acceptance
        in_instr = vecs[0].instr; in_pc = vecs[0].pc;
        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_stay", {31'd0, in_ready}, 1);
        chk("fl_idle_bf", {28'd0, bceu_bf}, 0);
        step();
        chk("fl_idle_no_res", {31'd0, res_valid}, 0);

        // Reset while in RESP
        res_ready = 1'b0;
        accept_eval(vecs[0], "rst_resp");
        step();
        chk_resp(vecs[0], "rst_resp");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("rst_resp_valid", {31'd0, res_valid}, 0);
        chk("rst_resp_in_ready", {31'd0, in_ready}, 1);
        chk("rst_resp_target", res_target, 0);
        chk("rst_resp_pc", res_pc, 0);
        chk_cnt("rst_resp");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
